// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_pkg                                                          |
// | Shared types and defaults for the counter sweep controller.          |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package counter_pkg;

  localparam int c_DEF_WIDTH   = 5;
  localparam int c_DEF_MAX_VAL = 30;

  localparam logic c_UP   = 1'b0;
  localparam logic c_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sweep_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sweep_step                                                           |
// | Next-count, direction and target-range unit for the sweep controller.|
// | Macro SWEEP_WRAP_EN: modulo-(MAX_VAL+1) ring stepping, shortest path.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sweep_step
  import counter_pkg::*;
#(
  parameter int WIDTH   = c_DEF_WIDTH,
  parameter int MAX_VAL = c_DEF_MAX_VAL
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] next,
  output logic             hit,
  output logic             dir,
  output logic             over
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

`ifdef SWEEP_WRAP_EN
  localparam logic [WIDTH+1:0] c_RING = (WIDTH+2)'(MAX_VAL + 1);

  logic [WIDTH+1:0] w_dist_up;

  always_comb begin
    w_dist_up = '0;
    if (target >= count) begin
      w_dist_up = {2'b00, target - count};
    end else begin
      w_dist_up = c_RING - {2'b00, count - target};
    end
  end

  // Up wins ties: 2*up_distance <= ring size means up is not longer.
  assign dir = ({w_dist_up[WIDTH:0], 1'b0} <= c_RING) ? c_UP : c_DOWN;

  always_comb begin
    next = count;
    if (mode == c_UP) begin
      next = (count == c_MAX) ? '0 : count + c_ONE;
    end else begin
      next = (count == '0) ? c_MAX : count - c_ONE;
    end
  end
`else
  assign dir  = (target > count) ? c_UP : c_DOWN;
  assign next = (mode == c_UP) ? count + c_ONE : count - c_ONE;
`endif

  assign hit  = (next == target);
  assign over = (target > c_MAX);

endmodule
`default_nettype wire

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_sweep_ctrl                                                   |
// | Round-robin arbitrated, holdable up/down counter sweep controller.   |
// | Optional macro SWEEP_WRAP_EN (see sweep_step).                       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH   = c_DEF_WIDTH,
  parameter int MAX_VAL = c_DEF_MAX_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_target,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_target,
  output logic             req1_ready,
  input  logic             hold,
  output logic [WIDTH-1:0] counter,
  output logic             mode,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             err
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_target;
  logic             r_mode;
  logic             r_owner;
  logic             r_prio;
  logic             r_err;

  logic             w_any;
  logic             w_winner;
  logic [WIDTH-1:0] w_sel_target;
  logic [WIDTH-1:0] w_step_target;
  logic [WIDTH-1:0] w_next_count;
  logic             w_zero;
  logic             w_hit;
  logic             w_dir;
  logic             w_bad;
  logic             w_accept;
  logic             w_step;

  // r_prio names the requester that wins a tie.
  assign w_any        = req0_valid | req1_valid;
  assign w_winner     = (req0_valid & req1_valid) ? r_prio : req1_valid;
  assign w_sel_target = w_winner ? req1_target : req0_target;
  assign w_zero       = (w_sel_target == r_counter);

  // The step unit sees the candidate target in IDLE and the latched one while running.
  assign w_step_target = (r_state == IDLE) ? w_sel_target : r_target;

  sweep_step #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_step (
    .count  (r_counter),
    .mode   (r_mode),
    .target (w_step_target),
    .next   (w_next_count),
    .hit    (w_hit),
    .dir    (w_dir),
    .over   (w_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_accept   = 1'b1;
          req0_ready = ~w_winner;
          req1_ready = w_winner;
          if (!w_bad) begin
            w_next_state = w_zero ? DONE : RUN;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          w_step = 1'b1;
          if (w_hit) begin
            w_next_state = DONE;
          end
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_counter <= '0;
      r_target  <= '0;
      r_mode    <= c_UP;
      r_owner   <= 1'b0;
      r_prio    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept & w_bad;
      // Rejected commands leave owner, pointer and mode untouched.
      if (w_accept && !w_bad) begin
        r_owner  <= w_winner;
        r_prio   <= ~w_winner;
        r_target <= w_sel_target;
        if (!w_zero) begin
          r_mode <= w_dir;
        end
      end
      if (w_step) begin
        r_counter <= w_next_count;
      end
    end
  end

  assign counter = r_counter;
  assign mode    = r_mode;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign done_id = r_owner;
  assign err     = r_err;

endmodule
`default_nettype wire
